// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM bank arbiter.
//   arb_state_e : controller state (INIT = zero-filling the bank, RUN = serving requesters)
//   DataWidth   : bank word width in bits
//   BeWidth     : byte enables per word
package sram_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    localparam int DataWidth = 32;
    localparam int BeWidth   = DataWidth / 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request found scanning upward from rr_ptr, wrapping
// modulo NumPorts. The pointer register itself lives in the parent.
// Ports:
//   req     in  NumPorts      request vector
//   rr_ptr  in  PortIdxWidth  highest-priority port this cycle
//   gnt     out NumPorts      one-hot grant, or zero when nothing is requested
//   winner  out PortIdxWidth  index of the granted port (0 when none)
//   any_gnt out 1             a grant is being issued
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NumPorts     = 2,
    parameter int PortIdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0]     req,
    input  logic [PortIdxWidth-1:0] rr_ptr,
    output logic [NumPorts-1:0]     gnt,
    output logic [PortIdxWidth-1:0] winner,
    output logic                    any_gnt
);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    localparam int SumWidth = PortIdxWidth + 1;

    logic                    found;
    logic [SumWidth-1:0]     sum;
    logic [PortIdxWidth-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NumPorts; i++) begin
            sum = {1'b0, rr_ptr} + SumWidth'(i);
            if (sum >= SumWidth'(NumPorts)) begin
                sum = sum - SumWidth'(NumPorts);
            end
            idx = sum[PortIdxWidth-1:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign any_gnt = found;

    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_gnt
            assign gnt[gi] = found && (winner == PortIdxWidth'(gi));
        end
    endgenerate

endmodule

// File: rtl/sram_bank_arbiter.sv
// Shares one single-port, byte-enabled SRAM bank among NumPorts requesters.
// After reset (when InitOnReset) and on every scrub request the bank is
// zero-filled, one word per cycle, before any requester is granted. In RUN
// the bank goes to a round-robin winner each cycle; the response (rvalid) comes
// back one cycle after the grant, for reads and writes alike.
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   req_i/we_i/addr_i/wdata_i/be_i   per-port request and payload (flattened)
//   gnt_o                            per-port grant, combinational from req_i
//   rvalid_o                         per-port response valid, one cycle after grant
//   rdata_o                          shared read data, qualified by rvalid_o
//   scrub_req_i                      pulse: re-run the zero-fill (ignored in INIT)
//   init_done_o                      high while serving requesters
//   mem_*                            bank interface, mem_rdata_i valid 1 cycle after a read
module sram_bank_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NumWords     = 8192,
    parameter int NumPorts     = 2,
    parameter bit InitOnReset  = 1'b1,
    parameter int AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int PortIdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumPorts-1:0]            req_i,
    input  logic [NumPorts-1:0]            we_i,
    input  logic [NumPorts*AddrWidth-1:0]  addr_i,
    input  logic [NumPorts*DataWidth-1:0]  wdata_i,
    input  logic [NumPorts*BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0]            gnt_o,
    output logic [NumPorts-1:0]            rvalid_o,
    output logic [DataWidth-1:0]           rdata_o,
    input  logic                           scrub_req_i,
    output logic                           init_done_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [AddrWidth-1:0]           mem_addr_o,
    output logic [DataWidth-1:0]           mem_wdata_o,
    output logic [BeWidth-1:0]             mem_be_o,
    input  logic [DataWidth-1:0]           mem_rdata_i
);

    localparam logic [AddrWidth-1:0]    LastAddr   = AddrWidth'(NumWords - 1);
    localparam logic [PortIdxWidth-1:0] LastPort   = PortIdxWidth'(NumPorts - 1);
    localparam arb_state_e              ResetState = InitOnReset ? INIT : RUN;

    arb_state_e              state_reg, state_next;
    logic [AddrWidth-1:0]    init_cnt_reg, init_cnt_next;
    logic [PortIdxWidth-1:0] rr_ptr_reg, rr_ptr_next;
    logic                    rvalid_reg, rvalid_next;
    logic [PortIdxWidth-1:0] resp_idx_reg, resp_idx_next;

    logic [AddrWidth-1:0]    addr_arr  [NumPorts];
    logic [DataWidth-1:0]    wdata_arr [NumPorts];
    logic [BeWidth-1:0]      be_arr    [NumPorts];

    logic [NumPorts-1:0]     arb_gnt;
    logic [PortIdxWidth-1:0] winner;
    logic                    any_gnt;

    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
            assign addr_arr[gi]  = addr_i[gi*AddrWidth +: AddrWidth];
            assign wdata_arr[gi] = wdata_i[gi*DataWidth +: DataWidth];
            assign be_arr[gi]    = be_i[gi*BeWidth +: BeWidth];
            // Only one response can be outstanding, so a single index suffices.
            assign rvalid_o[gi]  = rvalid_reg && (resp_idx_reg == PortIdxWidth'(gi));
        end
    endgenerate

    rr_arbiter #(
        .NumPorts     (NumPorts),
        .PortIdxWidth (PortIdxWidth)
    ) u_rr_arbiter (
        .req     (req_i),
        .rr_ptr  (rr_ptr_reg),
        .gnt     (arb_gnt),
        .winner  (winner),
        .any_gnt (any_gnt)
    );

    assign init_done_o = (state_reg == RUN);
    assign rdata_o     = mem_rdata_i;

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = '0;
        rr_ptr_next   = rr_ptr_reg;
        rvalid_next   = 1'b0;
        resp_idx_next = resp_idx_reg;
        gnt_o         = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_be_o      = '0;

        case (state_reg)
            INIT: begin
                // The bank is kept idle while reset is held.
                mem_req_o  = rst_ni;
                mem_we_o   = 1'b1;
                mem_be_o   = '1;
                mem_addr_o = init_cnt_reg;
                if (init_cnt_reg == LastAddr) begin
                    state_next = RUN;
                end else begin
                    init_cnt_next = init_cnt_reg + AddrWidth'(1);
                end
            end
            RUN: begin
                gnt_o       = rst_ni ? arb_gnt : '0;
                mem_req_o   = rst_ni && any_gnt;
                mem_we_o    = we_i[winner];
                mem_addr_o  = addr_arr[winner];
                mem_wdata_o = wdata_arr[winner];
                mem_be_o    = be_arr[winner];
                if (any_gnt) begin
                    rvalid_next   = 1'b1;
                    resp_idx_next = winner;
                    if (NumPorts > 1) begin
                        rr_ptr_next = (winner == LastPort) ? '0 : winner + PortIdxWidth'(1);
                    end
                end
                // The grant issued in this cycle still completes; its
                // response shows up during the first INIT cycle.
                if (scrub_req_i) begin
                    state_next = INIT;
                end
            end
            default: state_next = ResetState;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg    <= ResetState;
            init_cnt_reg <= '0;
            rr_ptr_reg   <= '0;
            rvalid_reg   <= 1'b0;
            resp_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
            rvalid_reg   <= rvalid_next;
            resp_idx_reg <= resp_idx_next;
        end
    end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter (NumWords=16, NumPorts=2). Includes a behavioural
// SRAM bank and a reference model working from the arbitration/response rules.
module tb_sram_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [3:0]  a  [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic        scrub;

    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic        init_done, mem_req, mem_we;
    logic [3:0]  mem_addr, mem_be;
    logic [7:0]  addr_bus, be_bus;
    logic [63:0] wdata_bus;

    assign addr_bus  = {a[1], a[0]};
    assign be_bus    = {be[1], be[0]};
    assign wdata_bus = {wd[1], wd[0]};

    always #5 clk = ~clk;

    sram_bank_arbiter #(
        .NumWords    (16),
        .NumPorts    (2),
        .InitOnReset (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr_bus),
        .wdata_i     (wdata_bus),
        .be_i        (be_bus),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .scrub_req_i (scrub),
        .init_done_o (init_done),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata)
    );

    // Behavioural bank: byte-enabled writes, 1-cycle read latency.
    logic [31:0] bank [16];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) bank[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= bank[mem_addr];
            end
        end
    end

    // Reference model state.
    int          n_vec = 0, n_bad = 0;
    int          init_left = 16;  // zero-fill cycles still to go (0 = serving)
    int          ptr = 0;         // port with priority
    logic [31:0] ref_mem [16];
    bit          pend_valid = 0;
    int          pend_port = 0;
    bit          pend_read = 0;
    logic [31:0] pend_data = '0;
    logic [1:0]  last_gnt = '0;
    logic [1:0]  obs_gnt, obs_rv;
    logic [31:0] obs_rdata;
    logic        obs_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs already driven; compare, advance model, move to next negedge.
    task automatic step();
        logic [1:0]  eg;
        logic        emreq, ewe;
        logic [3:0]  eaddr, ebe;
        logic [31:0] ewd;
        int          w, p;
        bit          npv;
        #1;
        obs_gnt = gnt; obs_rv = rvalid; obs_rdata = rdata; obs_done = init_done;
        eg = '0; w = -1;
        if (rst_n && init_left == 0) begin
            for (int k = 0; k < 2; k++) begin
                p = (ptr + k) % 2;
                if (w < 0 && req[p]) w = p;
            end
            if (w >= 0) eg[w] = 1'b1;
        end
        emreq = !rst_n ? 1'b0 : (init_left > 0 ? 1'b1 : (w >= 0));
        check("gnt", 32'(gnt), 32'(eg));
        check("mem_req", 32'(mem_req), 32'(emreq));
        if (emreq) begin
            if (init_left > 0) begin
                ewe = 1'b1; eaddr = 4'(16 - init_left); ebe = 4'hF; ewd = '0;
            end else begin
                ewe = we[w]; eaddr = a[w]; ebe = be[w]; ewd = wd[w];
            end
            check("mem_we", 32'(mem_we), 32'(ewe));
            check("mem_addr", 32'(mem_addr), 32'(eaddr));
            if (ewe) begin
                check("mem_be", 32'(mem_be), 32'(ebe));
                check("mem_wdata", mem_wdata, ewd);
            end
        end
        check("init_done", 32'(init_done), 32'(init_left == 0));
        check("rvalid", 32'(rvalid), pend_valid ? (32'(1) << pend_port) : 32'(0));
        if (pend_valid && pend_read) check("rdata", rdata, pend_data);

        npv = 0;
        if (!rst_n) begin
            init_left = 16; ptr = 0;
        end else if (init_left > 0) begin
            ref_mem[16 - init_left] = '0;
            init_left--;
        end else begin
            if (w >= 0) begin
                npv = 1; pend_port = w; pend_read = !we[w];
                pend_data = ref_mem[a[w]];
                if (we[w])
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) ref_mem[a[w]][8*b +: 8] = wd[w][8*b +: 8];
                ptr = (w + 1) % 2;
            end
            if (scrub) init_left = 16;
        end
        pend_valid = npv;
        last_gnt = eg;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  req, we;
        logic [3:0]  a0, a1;
        logic [31:0] wd0, wd1;
        logic [3:0]  be0, be1;
        logic [1:0]  exp_gnt, exp_rv;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];
    int   first_done;

    initial begin
        for (int i = 0; i < 16; i++) begin
            bank[i] = $urandom;
            ref_mem[i] = '0;
        end
        mem_rdata = '0;
        rst_n = 1'b0; req = '0; we = '0; scrub = 1'b0;
        for (int p = 0; p < 2; p++) begin a[p] = '0; wd[p] = '0; be[p] = '0; end

        //              req    we     a0 a1 wd0           wd1           be0   be1   gnt    rv     chk rdata
        vecs[0]  = '{2'b01, 2'b01, 5, 0, 32'hDEADBEEF, 32'h0,        4'hF, 4'h0, 2'b01, 2'b00, 0, 32'h0};
        vecs[1]  = '{2'b01, 2'b00, 5, 0, 32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 0, 32'h0};
        vecs[2]  = '{2'b00, 2'b00, 0, 0, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b01, 1, 32'hDEADBEEF};
        vecs[3]  = '{2'b10, 2'b10, 0, 3, 32'h0,        32'h11223344, 4'h0, 4'h5, 2'b10, 2'b00, 0, 32'h0};
        vecs[4]  = '{2'b10, 2'b00, 0, 3, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b10, 0, 32'h0};
        vecs[5]  = '{2'b00, 2'b00, 0, 0, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b10, 1, 32'h00220044};
        vecs[6]  = '{2'b11, 2'b00, 5, 3, 32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b00, 0, 32'h0};
        vecs[7]  = '{2'b11, 2'b00, 5, 3, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b01, 1, 32'hDEADBEEF};
        vecs[8]  = '{2'b11, 2'b00, 5, 3, 32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b10, 1, 32'h00220044};
        vecs[9]  = '{2'b11, 2'b00, 5, 3, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b01, 1, 32'hDEADBEEF};
        vecs[10] = '{2'b00, 2'b00, 0, 0, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b10, 1, 32'h00220044};

        repeat (2) @(negedge clk);
        step();  // reset state

        // Zero-fill after reset with port1 already requesting.
        rst_n = 1'b1; req = 2'b10; we = 2'b00; a[1] = 4'd7;
        first_done = 0;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c < 17) check("init_gnt", 32'(obs_gnt), 32'(0));
            if (obs_done && first_done == 0) first_done = c;
        end
        check("init_done_cycle", 32'(first_done), 32'(17));
        check("held_req_gnt", 32'(obs_gnt), 32'(2'b10));
        req = 2'b00;
        step();
        check("held_req_rvalid", 32'(obs_rv), 32'(2'b10));

        // Table-driven vectors.
        for (int i = 0; i < 11; i++) begin
            req = vecs[i].req; we = vecs[i].we;
            a[0] = vecs[i].a0; a[1] = vecs[i].a1;
            wd[0] = vecs[i].wd0; wd[1] = vecs[i].wd1;
            be[0] = vecs[i].be0; be[1] = vecs[i].be1;
            step();
            check($sformatf("vec%0d_gnt", i), 32'(obs_gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("vec%0d_rvalid", i), 32'(obs_rv), 32'(vecs[i].exp_rv));
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), obs_rdata, vecs[i].exp_rd);
        end

        // Scrub while port0 is granted; scrub re-asserted during INIT is ignored.
        req = 2'b01; we = 2'b00; a[0] = 4'd5; scrub = 1'b1;
        step();
        check("scrub_gnt", 32'(obs_gnt), 32'(2'b01));
        req = 2'b00;
        step();
        check("scrub_rvalid", 32'(obs_rv), 32'(2'b01));
        check("scrub_rdata", obs_rdata, 32'hDEADBEEF);
        for (int c = 0; c < 15; c++) begin
            scrub = (c < 10);
            step();
        end
        scrub = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            req = (k < 16) ? 2'b01 : 2'b00;
            a[0] = 4'(k);
            step();
            if (k == 0) check("scrub_done", 32'(obs_done), 32'(1));
            if (k > 0) check($sformatf("scrub_zero%0d", k - 1), obs_rdata, 32'h0);
        end

        // Randomized traffic; requesters hold req and payload until granted.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            scrub = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!(req[p] && !last_gnt[p])) begin
                    req[p] = ($urandom_range(0, 2) != 0);
                    we[p]  = 1'($urandom_range(0, 1));
                    a[p]   = 4'($urandom_range(0, 15));
                    wd[p]  = $urandom;
                    be[p]  = 4'($urandom_range(0, 15));
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
